// File: rtl/conv_mem_responder.sv
// -----------------------------------------------------------------------------
// conv_mem_responder
// Responder side of the convolution accelerator memory interface. Holds the
// 64x64 input image and the five layer-output banks (L0K0, L0K1, L1K0, L1K1,
// L2). It issues the one-cycle ready pulse that starts the engine and tracks
// the busy handshake. It serves image and layer reads and absorbs layer
// writes. Protocol violations are flagged on a sticky err output.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   ready               one-cycle start pulse to the engine
//   busy                engine running flag
//   iaddr / idata       image read port (combinational)
//   cwr, caddr_wr,
//   cdata_wr            layer write port, bank chosen by csel
//   crd, caddr_rd,
//   cdata_rd            layer read port (combinational), bank chosen by csel
//   csel                bank select 1..5, all other codes invalid
//   host_we, host_addr,
//   host_wdata          image load port, honoured only in IDLE/DONE
//   host_start          request a run
//   host_rsel,
//   host_rdata          readback (0 = image, 1..5 = bank), combinational
//   done                run finished, held until the next host_start
//   err                 sticky protocol error, cleared by reset only
//   state_o             current FSM state for debug
// -----------------------------------------------------------------------------
module conv_mem_responder #(
   parameter int DW           = 20,
   parameter int AW           = 12,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   input  logic          host_start,
   input  logic [2:0]    host_rsel,
   output logic [DW-1:0] host_rdata,
   output logic          done,
   output logic          err,
   output logic [2:0]    state_o
);

   localparam int DEPTH = 2**AW;
   localparam int CW    = $clog2(BUSY_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [DW-1:0] img_q  [0:DEPTH-1];
   logic [DW-1:0] bank_q [0:4][0:DEPTH-1];

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          host_ok;

   function automatic logic sel_valid(input logic [2:0] s);
      return (s >= 3'd1) && (s <= 3'd5);
   endfunction

   // Invalid codes map to bank 0 so the index never leaves the array; every
   // caller qualifies the result with sel_valid.
   function automatic logic [2:0] sel_idx(input logic [2:0] s);
      return sel_valid(s) ? (s - 3'd1) : 3'd0;
   endfunction

   assign host_ok = (state_q == S_IDLE) || (state_q == S_DONE);

   // Addresses are AW bits wide, so border fetches such as 0-65 wrap
   // naturally onto the image.
   assign idata = img_q[iaddr];

   always_comb begin
      cdata_rd = '0;
      if (crd && sel_valid(csel)) begin
         cdata_rd = bank_q[sel_idx(csel)][caddr_rd];
      end
   end

   always_comb begin
      host_rdata = '0;
      if (host_rsel == 3'd0) begin
         host_rdata = img_q[host_addr];
      end else if (sel_valid(host_rsel)) begin
         host_rdata = bank_q[sel_idx(host_rsel)][host_addr];
      end
   end

   // Memories are never cleared. Reads are combinational from the stored
   // array, so a same-cycle read of a location being written sees old data.
   always_ff @(posedge clk) begin
      if (!reset && host_we && host_ok) begin
         img_q[host_addr] <= host_wdata;
      end
      if (!reset && cwr && sel_valid(csel)) begin
         bank_q[sel_idx(csel)][caddr_wr] <= cdata_wr;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      if (cwr && !sel_valid(csel))            err_d = 1'b1;
      if (cwr && crd)                         err_d = 1'b1;
      if ((cwr || crd) && state_q != S_RUN)   err_d = 1'b1;
      if (busy && state_q == S_IDLE)          err_d = 1'b1;
      if (host_we && !host_ok)                err_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (host_start) state_d = S_START;
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // cnt_q counts the idle waiting cycles already spent; the run is
            // abandoned on the BUSY_TIMEOUT-th one.
            if (busy) begin
               state_d = S_RUN;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!busy) state_d = S_DONE;
         end
         S_DONE: begin
            if (host_start) state_d = S_START;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign ready   = (state_q == S_START);
   assign done    = (state_q == S_DONE);
   assign err     = err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
module tb_conv_mem_responder;

   localparam int DW = 20;
   localparam int AW = 12;
   localparam int BT = 16;

   localparam int M_IDLE  = 0;
   localparam int M_START = 1;
   localparam int M_WAIT  = 2;
   localparam int M_RUN   = 3;
   localparam int M_DONE  = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          ready;
   logic          busy;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] idata;
   logic          cwr;
   logic [AW-1:0] caddr_wr;
   logic [DW-1:0] cdata_wr;
   logic          crd;
   logic [AW-1:0] caddr_rd;
   logic [DW-1:0] cdata_rd;
   logic [2:0]    csel;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_start;
   logic [2:0]    host_rsel;
   logic [DW-1:0] host_rdata;
   logic          done;
   logic          err;
   logic [2:0]    state_o;

   conv_mem_responder #(.DW(DW), .AW(AW), .BUSY_TIMEOUT(BT)) dut (
      .clk(clk), .reset(reset), .ready(ready), .busy(busy),
      .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
      .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_start(host_start), .host_rsel(host_rsel), .host_rdata(host_rdata),
      .done(done), .err(err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Reference model: memories as plain arrays, run phase as an integer.
   logic [DW-1:0] img_m  [4096];
   logic [DW-1:0] bank_m [5][4096];
   int            mstate = M_IDLE;
   int            mwait  = 0;
   bit            merr   = 1'b0;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctrl(input string tag);
      chk({tag, "_state"}, 32'(state_o), 32'(mstate));
      chk({tag, "_ready"}, 32'(ready), 32'(mstate == M_START));
      chk({tag, "_done"},  32'(done),  32'(mstate == M_DONE));
      chk({tag, "_err"},   32'(err),   32'(merr));
   endtask

   // Apply the behavioural rules for the inputs currently driven, then clock.
   task automatic step();
      bit sv;
      sv = (csel >= 3'd1) && (csel <= 3'd5);
      if (reset) begin
         mstate = M_IDLE;
         mwait  = 0;
         merr   = 1'b0;
      end else begin
         if (cwr && !sv) merr = 1'b1;
         if (cwr && crd) merr = 1'b1;
         if ((cwr || crd) && mstate != M_RUN) merr = 1'b1;
         if (busy && mstate == M_IDLE) merr = 1'b1;
         if (host_we) begin
            if (mstate == M_IDLE || mstate == M_DONE) img_m[host_addr] = host_wdata;
            else merr = 1'b1;
         end
         if (cwr && sv) bank_m[csel - 1][caddr_wr] = cdata_wr;
         case (mstate)
            M_IDLE:  if (host_start) mstate = M_START;
            M_START: begin mwait = 0; mstate = M_WAIT; end
            M_WAIT: begin
               if (busy) mstate = M_RUN;
               else if (mwait + 1 >= BT) begin merr = 1'b1; mstate = M_DONE; end
               else mwait++;
            end
            M_RUN:   if (!busy) mstate = M_DONE;
            M_DONE:  if (host_start) mstate = M_START;
            default: mstate = M_IDLE;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bank_write(input logic [2:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
      cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
      step();
      cwr = 1'b0;
   endtask

   task automatic check_img(input string tag, input int n);
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         a = AW'($urandom);
         host_rsel = 3'd0; host_addr = a; iaddr = a;
         #1;
         chk({tag, "_host"}, 32'(host_rdata), 32'(img_m[a]));
         chk({tag, "_idata"}, 32'(idata), 32'(img_m[a]));
      end
   endtask

   initial begin : main
      logic [DW-1:0] r, old;
      logic [AW-1:0] a;
      logic [2:0]    s;
      int            n;
      logic [2:0]    wsel [$];
      logic [AW-1:0] wadr [$];

      reset = 1'b1; busy = 1'b0; iaddr = '0; cwr = 1'b0; caddr_wr = '0;
      cdata_wr = '0; crd = 1'b0; caddr_rd = '0; csel = 3'd0; host_we = 1'b0;
      host_addr = '0; host_wdata = '0; host_start = 1'b0; host_rsel = 3'd0;
      step(); step();
      reset = 1'b0;
      chk("rst_ready", 32'(ready), 0);
      chk("rst_state", 32'(state_o), M_IDLE);
      chk_ctrl("rst");

      // Image load img[k] = k
      host_we = 1'b1;
      for (int k = 0; k < 4096; k++) begin
         host_addr = AW'(k); host_wdata = DW'(k);
         step();
      end
      host_we = 1'b0;
      chk_ctrl("load");
      check_img("load", 6);

      // Start pulse
      host_start = 1'b1; step(); host_start = 1'b0;
      chk("ready_hi", 32'(ready), 1);
      chk_ctrl("start");
      step();
      chk("ready_lo", 32'(ready), 0);
      chk_ctrl("wait");

      // Wrapped and plain image reads
      a = 12'd0 - 12'd65; iaddr = a; #1;
      chk("idata_wrap", 32'(idata), 32'h00FBF);
      iaddr = 12'd5; #1;
      chk("idata_5", 32'(idata), 5);
      check_img("rand", 4);

      busy = 1'b1; step();
      chk_ctrl("run");

      // Bank write, read-back, bank isolation
      bank_write(3'b010, 12'h123, 20'hABCDE);
      r = DW'($urandom);
      if (r == 20'hABCDE) r = r ^ 20'h1;
      bank_write(3'b001, 12'h123, r);
      for (int b = 3; b <= 5; b++) bank_write(3'(b), 12'h123, DW'($urandom));
      crd = 1'b1; csel = 3'b010; caddr_rd = 12'h123; #1;
      chk("rd_l0k1", 32'(cdata_rd), 32'hABCDE);
      csel = 3'b001; #1;
      chk("rd_l0k0", 32'(cdata_rd), 32'(bank_m[0][12'h123]));
      chk("rd_l0k0_ne", 32'(cdata_rd != 20'hABCDE), 1);
      crd = 1'b0; #1;
      chk("rd_off", 32'(cdata_rd), 0);

      // Random traffic, then a known L2 word at 7
      for (int i = 0; i < 12; i++) begin
         s = 3'($urandom_range(1, 5)); a = AW'($urandom);
         bank_write(s, a, DW'($urandom));
         wsel.push_back(s); wadr.push_back(a);
      end
      bank_write(3'b101, 12'd7, DW'($urandom));
      for (int i = 0; i < 12; i += 2) begin
         crd = 1'b1; csel = wsel[i]; caddr_rd = wadr[i]; #1;
         chk("rd_rand", 32'(cdata_rd), 32'(bank_m[wsel[i] - 1][wadr[i]]));
      end
      crd = 1'b0;
      chk_ctrl("run_traffic");

      // Busy falls -> done next cycle
      busy = 1'b0; step();
      chk("done_after_fall", 32'(done), 1);
      chk_ctrl("done1");
      host_rsel = 3'b101; host_addr = 12'd7; #1;
      chk("host_l2_7", 32'(host_rdata), 32'(bank_m[4][7]));
      step();
      chk("done_held", 32'(done), 1);

      // Busy never rises -> timeout
      host_start = 1'b1; step(); host_start = 1'b0;
      chk("to_ready", 32'(ready), 1);
      chk("to_done_clr", 32'(done), 0);
      n = 0;
      while (!done && n < 40) begin step(); n++; end
      chk("timeout_cycles", 32'(n), BT + 1);
      chk("timeout_err", 32'(err), 1);
      chk_ctrl("timeout");

      // Restart: err sticks
      host_start = 1'b1; step(); host_start = 1'b0;
      chk_ctrl("restart");
      step(); busy = 1'b1; step();
      chk_ctrl("run2");
      chk("err_sticky", 32'(err), 1);

      // Same-cycle read and write return old data
      old = bank_m[1][12'h123];
      r = DW'($urandom);
      cwr = 1'b1; crd = 1'b1; csel = 3'b010; caddr_wr = 12'h123; caddr_rd = 12'h123;
      cdata_wr = r; #1;
      chk("rw_old", 32'(cdata_rd), 32'(old));
      step();
      cwr = 1'b0; #1;
      chk("rw_new", 32'(cdata_rd), 32'(bank_m[1][12'h123]));
      crd = 1'b0;

      // Reset mid-run
      reset = 1'b1; busy = 1'b0; step(); reset = 1'b0;
      chk("midrst_state", 32'(state_o), M_IDLE);
      chk("midrst_err", 32'(err), 0);
      chk_ctrl("midrst");
      check_img("midrst", 4);

      // Clean run: invalid csel write, host_we in RUN
      host_start = 1'b1; step(); host_start = 1'b0;
      step(); busy = 1'b1; step();
      chk_ctrl("run3");
      bank_write(3'b110, 12'h123, DW'($urandom));
      chk("badsel_err", 32'(err), 1);
      for (int b = 1; b <= 5; b++) begin
         host_rsel = 3'(b); host_addr = 12'h123; #1;
         chk("badsel_bank", 32'(host_rdata), 32'(bank_m[b - 1][12'h123]));
      end
      crd = 1'b1; csel = 3'b110; caddr_rd = 12'h123; #1;
      chk("badsel_rd", 32'(cdata_rd), 0);
      crd = 1'b0;
      host_we = 1'b1; host_addr = 12'd9; host_wdata = ~img_m[9]; step(); host_we = 1'b0;
      check_img("we_run", 1);
      host_rsel = 3'd0; host_addr = 12'd9; #1;
      chk("we_run_ign", 32'(host_rdata), 32'(img_m[9]));
      busy = 1'b0; step();
      chk_ctrl("done3");

      // busy while idle
      reset = 1'b1; step(); reset = 1'b0;
      busy = 1'b1; step(); busy = 1'b0;
      chk_ctrl("busy_idle");

      // cwr outside RUN: error, but write lands
      reset = 1'b1; step(); reset = 1'b0;
      r = DW'($urandom);
      bank_write(3'b100, 12'hFFF, r);
      chk_ctrl("wr_idle");
      host_rsel = 3'b100; host_addr = 12'hFFF; #1;
      chk("wr_idle_data", 32'(host_rdata), 32'(r));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Responder end of the convolution accelerator memory interface: owns the 64x64 input image memory and the five layer-output banks that the conv engine addresses through csel.
- Drives the ready start pulse, serves iaddr/caddr_rd reads, and absorbs cwr writes.
- Watches the busy handshake and reports completion and protocol errors.
- Gives a host port for loading the image before a run and reading back any bank after a run.

Parameters:
DW, 20, data width of image and layer words
AW, 12, address width (DEPTH = 2**AW words per memory)
BUSY_TIMEOUT, 16, cycles allowed between ready pulse and busy rising

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
ready  out  1  one-cycle start pulse to engine
busy  in  1  engine running flag
iaddr  in  AW  image read address
idata  out  DW  image read data
cwr  in  1  layer write strobe
caddr_wr  in  AW  layer write address
cdata_wr  in  DW  layer write data
crd  in  1  layer read strobe
caddr_rd  in  AW  layer read address
cdata_rd  out  DW  layer read data
csel  in  3  bank select: 001 L0K0, 010 L0K1, 011 L1K0, 100 L1K1, 101 L2; others invalid
host_we  in  1  image load strobe
host_addr  in  AW  image load / readback address
host_wdata  in  DW  image load data
host_start  in  1  request a run
host_rsel  in  3  readback bank select (same encoding as csel; 000 = image)
host_rdata  out  DW  readback data, combinational from host_rsel/host_addr
done  out  1  run finished, held until next host_start
err  out  1  sticky protocol error
state_o  out  3  current FSM state for debug

Behaviour:
- Interface fixed: one clock clk; reset is synchronous and active-high.
- Reset values: ready=0, done=0, err=0, state_o=IDLE. Memories are not cleared.
- idata = img[iaddr], combinational from the current iaddr. Data is valid in the same cycle the address is presented, because the engine registers the address and captures the data on the next edge.
- cdata_rd = bank[csel][caddr_rd] when crd=1 and csel is valid; otherwise 0. Combinational.
- Layer write: on a clk edge with cwr=1 and valid csel, bank[csel][caddr_wr] <= cdata_wr. Any write is visible to a read in the following cycle. A read and a write to the same address in the same cycle return the old data.
- host_we writes img[host_addr] only in IDLE or DONE. A host_we in any other state is ignored and sets err.
- FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
  - IDLE: host_start=1 -> START.
  - START: ready=1 for exactly this one cycle -> WAIT_BUSY. The timeout counter is cleared.
  - WAIT_BUSY: busy=1 -> RUN. If the counter reaches BUSY_TIMEOUT with busy still 0 -> set err, go to DONE.
  - RUN: busy falling to 0 -> DONE.
  - DONE: done=1. host_start=1 -> START, which clears done on entry.
- host_start is ignored in START, WAIT_BUSY and RUN.
- Protocol checks, each of which sets err (sticky, cleared only by reset):
  - cwr=1 with invalid csel.
  - cwr and crd both 1 in the same cycle.
  - cwr or crd asserted while state is not RUN. The write still happens if csel is valid.
  - busy=1 while in IDLE.
- Reset mid-run: FSM goes to IDLE, ready drops to 0, and memory contents are retained.
- Address wrap: all addresses are AW bits. The engine relies on modulo-2**AW wrap for border fetches (e.g. iaddr = 0 - 65), and those reads must return img at the wrapped index without error.

Test Plan:
1. Reset, then load img[k] = k for k = 0..4095 and pulse host_start -> ready is high for exactly 1 cycle, 1 cycle after host_start is sampled; state goes START -> WAIT_BUSY.
2. Drive iaddr=12'hFBF (0-65) -> idata = 20'h00FBF in the same cycle. Drive iaddr=5 -> idata=5.
3. In RUN, cwr=1, csel=010, caddr_wr=0x123, cdata_wr=0xABCDE. The next cycle, crd=1 with csel=010 and caddr_rd=0x123 -> cdata_rd=0xABCDE. Switching csel to 001 -> cdata_rd = bank1 contents at 0x123, not 0xABCDE.
4. busy stays 0 for 16 cycles after ready -> err=1 and done=1. A second host_start restarts the run, and err stays 1.
5. Drive busy high then low -> done=1 the cycle after busy falls. host_rsel=101, host_addr=7 -> host_rdata returns the L2 word previously written at 7.
6. cwr=1 with csel=110 -> no bank changes and err=1. Asserting reset for one cycle mid-RUN -> state_o=IDLE, ready=0, err=0, and image contents are unchanged.
